// File: rtl/serial_word_adder.sv
// Bit-serial LSB-first word adder: accumulates WIDTH operand bit pairs through a carry flop
// and shift register, then presents the sum and carry-out behind a valid/ready handshake.
module serial_word_adder #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_a_bit,
    input  logic             i_b_bit,
    input  logic             i_bit_valid,
    output logic [WIDTH-1:0] o_sum_out,
    output logic             o_cout,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             r_state;
    logic               r_carry;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_valid;
    logic               r_busy;

    logic               w_s;
    logic               w_carry_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_shreg_next;

    always_comb begin
        w_s          = i_a_bit ^ i_b_bit ^ r_carry;
        w_carry_next = (i_a_bit & i_b_bit) | (i_a_bit & r_carry) | (i_b_bit & r_carry);
        w_last       = (r_count == CNT_W'(WIDTH - 1));
        w_shreg_next = {w_s, r_shreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_carry <= 1'b0;
            r_count <= '0;
            r_shreg <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_state <= StShift;
                        r_carry <= 1'b0;
                        r_count <= '0;
                        r_shreg <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StShift: begin
                    // bit_valid low is a full stall: nothing advances
                    if (i_bit_valid) begin
                        r_carry <= w_carry_next;
                        r_shreg <= w_shreg_next;
                        if (w_last) begin
                            r_sum   <= w_shreg_next;
                            r_cout  <= w_carry_next;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_count <= '0;
                            r_state <= StDone;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (i_out_ready) begin
                        r_valid <= 1'b0;
                        if (i_start) begin
                            r_state <= StShift;
                            r_carry <= 1'b0;
                            r_count <= '0;
                            r_shreg <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_sum_out   = r_sum;
    assign o_cout      = r_cout;
    assign o_out_valid = r_valid;
    assign o_busy      = r_busy;

endmodule

// File: doc/serial_word_adder.md
Name: serial_word_adder

Overview:
Bit-serial, LSB-first word adder that sits directly downstream of the combinational 1-bit adder cell on the tt_um top.
- Adds a registered carry flop, bit counter and result shift register, so operand bit pairs arriving one per cycle on ui_in produce a full WIDTH-bit sum plus carry-out.
- Result is presented with a valid/ready handshake.
- Top-level pin mapping: a_bit=ui_in[0], b_bit=ui_in[1], bit_valid=ui_in[2], start=ui_in[3], out_ready=ui_in[4], sum_out=uo_out.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..16.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  begin a new word; sampled only in IDLE, or in DONE on the handshake cycle.
a_bit  input  1  operand A bit, LSB first.
b_bit  input  1  operand B bit, LSB first.
bit_valid  input  1  a_bit/b_bit valid this cycle; sampled only in SHIFT.
sum_out  output  WIDTH  registered sum word.
cout  output  1  registered carry-out of the MSB.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
busy  output  1  high while in SHIFT.

Behaviour:
Clock and reset:
- One clock domain.
- Reset is asynchronous and active-low; clock and reset ports are named clk and rst_n.

Reset values (applied immediately on rst_n=0):
- state=IDLE, carry=0, count=0, shreg=0.
- sum_out=0, cout=0, out_valid=0, busy=0.

State machine: IDLE, SHIFT, DONE.

IDLE:
- start=1 -> SHIFT next cycle; carry<=0, count<=0, shreg<=0.
- bit_valid and out_ready are ignored.

SHIFT (busy=1):
- On each cycle with bit_valid=1:
  - s = a^b^carry
  - carry <= (a&b)|(a&carry)|(b&carry)
  - shreg <= {s, shreg[WIDTH-1:1]}
  - count <= count+1
- bit_valid=0: full stall, no state change.
- start is ignored.
- When bit_valid=1 and count==WIDTH-1:
  - sum_out <= {s, shreg[WIDTH-1:1]}, cout <= carry_next.
  - out_valid <= 1, next state DONE, count <= 0.
- Latency: result visible on the cycle after the WIDTH-th accepted bit pair.
- Minimum word time: 1 (start) + WIDTH cycles.

DONE (out_valid=1):
- sum_out and cout are held stable until out_valid & out_ready.
- On handshake: out_valid <= 0, next state IDLE.
- If start=1 on the handshake cycle: go straight to SHIFT (back-to-back); carry, count and shreg are cleared as in IDLE.
- start without out_ready is ignored.
- bit_valid is ignored (no bits consumed while waiting).

Output persistence:
- sum_out and cout are not cleared after handshake.
- They keep the last result until the next word completes.

Arithmetic:
- Modulo 2^WIDTH; overflow is reported only via cout.
- No sign handling.

Async reset mid-word:
- Partial word is discarded.
- All outputs return to reset values in the same cycle as rst_n falls, with no clock required.
- First start after rst_n rises behaves as from power-up.

out_ready outside DONE: no effect.

Test Plan:
- WIDTH=8, start, then 8 consecutive bit pairs of A=0x5A, B=0x3C LSB first -> one cycle after the 8th pair: sum_out=0x96, cout=0, out_valid=1; busy low from that cycle.
- A=0xFF, B=0x01 -> sum_out=0x00, cout=1; A=0xFF, B=0xFF -> sum_out=0xFE, cout=1.
- A=0x5A, B=0x3C with bit_valid low for 3 cycles after bit 2 and 1 cycle after bit 5 -> same 0x96/0 result, completing exactly 4 cycles later than the unstalled case; count never advances on stall cycles.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles after completion -> sum_out/cout/out_valid stable, bit_valid toggling ignored. Then assert out_ready=1 and start=1 together -> next cycle busy=1, out_valid=0. Second word 0x01+0x02 -> 0x03, cout=0.
- Pull rst_n low mid-clock after 4 bits of 0xF0+0x0F -> outputs 0/IDLE immediately. Release, start fresh with 0x10+0x20 -> 0x30, cout=0, with no residue from the aborted carry or shreg.
- start pulsed during SHIFT and out_ready pulsed during IDLE/SHIFT -> no effect; result of the in-flight word unchanged.
